// File: rtl/m_msg_xfer.sv
// Frame sequencer between a TX/RX word buffer pair and an SPI word engine.
// Defining MSG_XFER_DEBOUNCE_EN makes start a debounced push-button input.
module m_msg_xfer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int DEB_DIV    = 27000,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  I_CLK,
  input  logic                  I_RESET,
  input  logic                  start,
  input  logic [ADDR_W:0]       len,
  input  logic                  tx_wr_en,
  input  logic [ADDR_W-1:0]     tx_waddr,
  input  logic [DATA_WIDTH-1:0] tx_wdata,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  byte_start,
  output logic [DATA_WIDTH-1:0] byte_tx,
  input  logic                  byte_done,
  input  logic [DATA_WIDTH-1:0] byte_rx,
  output logic                  busy,
  output logic                  frame_done,
  output logic [ADDR_W:0]       rx_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SEND = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  // A non-positive divider is a configuration error; start stays disabled then.
  localparam logic DEB_CFG_OK = (DEB_DIV > 0);

  logic [DATA_WIDTH-1:0] tx_mem [DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem [DEPTH];

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     idx_q, idx_d;
  logic [ADDR_W:0]       len_q, len_d;
  logic [ADDR_W:0]       rx_count_q, rx_count_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic                  byte_start_q, byte_start_d;
  logic [DATA_WIDTH-1:0] byte_tx_q, byte_tx_d;
  logic                  frame_done_q, frame_done_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rx_we_s;
  logic                  start_acc_s;
  logic [ADDR_W:0]       len_eff_s;
  logic                  last_s;

`ifdef MSG_XFER_DEBOUNCE_EN
  localparam logic [31:0] DEB_LAST = 32'(DEB_DIV - 1);

  logic [31:0] deb_cnt_q, deb_cnt_d;
  logic [4:0]  deb_sh_q, deb_sh_d;
  logic        deb_acc_q, deb_acc_d;

  // Sample the raw button once per tick; a press is one low sample then four highs.
  always_comb begin
    deb_cnt_d = deb_cnt_q + 32'd1;
    deb_sh_d  = deb_sh_q;
    deb_acc_d = 1'b0;
    if (deb_cnt_q >= DEB_LAST) begin
      deb_cnt_d = 32'd0;
      deb_sh_d  = {deb_sh_q[3:0], start};
      deb_acc_d = ({deb_sh_q[3:0], start} == 5'b01111);
    end else begin
      deb_acc_d = 1'b0;
    end
  end

  // Debounce state registers.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      deb_cnt_q <= 32'd0;
      deb_sh_q  <= 5'b00000;
      deb_acc_q <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      deb_sh_q  <= deb_sh_d;
      deb_acc_q <= deb_acc_d;
    end
  end

  assign start_acc_s = deb_acc_q & DEB_CFG_OK;
`else
  assign start_acc_s = start & DEB_CFG_OK;
`endif

  assign len_eff_s = ((len == (ADDR_W+1)'(0)) || (len > DEPTH_L)) ? DEPTH_L : len;
  assign last_s    = ({1'b0, idx_q} == (len_q - (ADDR_W+1)'(1)));

  // TX buffer write port; writes are accepted in every state.
  always_ff @(posedge I_CLK) begin
    if (tx_wr_en) begin
      tx_mem[tx_waddr] <= tx_wdata;
    end
  end

  // RX buffer capture of each completed word.
  always_ff @(posedge I_CLK) begin
    if (rx_we_s) begin
      rx_mem[idx_q] <= byte_rx;
    end
  end

  // Next-state and datapath for the frame sequencer.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    len_d        = len_q;
    rx_count_d   = rx_count_q;
    valid_d      = valid_q;
    byte_start_d = 1'b0;
    byte_tx_d    = byte_tx_q;
    frame_done_d = 1'b0;
    rx_we_s      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_acc_s) begin
          len_d      = len_eff_s;
          idx_d      = '0;
          valid_d    = '0;
          rx_count_d = '0;
          state_d    = S_LOAD;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_LOAD: begin
        byte_tx_d    = tx_mem[idx_q];
        byte_start_d = 1'b1;
        state_d      = S_SEND;
      end
      S_SEND: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (byte_done) begin
          rx_we_s        = 1'b1;
          valid_d[idx_q] = 1'b1;
          if (rx_count_q < DEPTH_L) begin
            rx_count_d = rx_count_q + (ADDR_W+1)'(1);
          end else begin
            rx_count_d = rx_count_q;
          end
          // Stop on the last word so idx never wraps past DEPTH-1.
          if (last_s) begin
            frame_done_d = 1'b1;
            state_d      = S_DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered read port; unwritten entries of the current frame read as zero.
  always_comb begin
    if (valid_q[rd_addr]) begin
      rd_data_d = rx_mem[rd_addr];
    end else begin
      rd_data_d = '0;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      len_q        <= '0;
      rx_count_q   <= '0;
      valid_q      <= '0;
      byte_start_q <= 1'b0;
      byte_tx_q    <= '0;
      frame_done_q <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      rx_count_q   <= rx_count_d;
      valid_q      <= valid_d;
      byte_start_q <= byte_start_d;
      byte_tx_q    <= byte_tx_d;
      frame_done_q <= frame_done_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign byte_start = byte_start_q;
  assign byte_tx    = byte_tx_q;
  assign frame_done = frame_done_q;
  assign rx_count   = rx_count_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_m_msg_xfer.sv
// Scoreboard bench for m_msg_xfer: an echoing SPI responder, a frame-level
// reference model and a monitor that checks every byte_start and frame_done.
module tb_m_msg_xfer;
  localparam int DW    = 8;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          I_CLK, I_RESET, start;
  logic [AW:0]   len;
  logic          tx_wr_en;
  logic [AW-1:0] tx_waddr, rd_addr;
  logic [DW-1:0] tx_wdata, rd_data, byte_tx, byte_rx;
  logic          byte_start, byte_done, busy, frame_done;
  logic [AW:0]   rx_count;

  m_msg_xfer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .DEB_DIV(4)) dut (
    .I_CLK(I_CLK), .I_RESET(I_RESET), .start(start), .len(len),
    .tx_wr_en(tx_wr_en), .tx_waddr(tx_waddr), .tx_wdata(tx_wdata),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .byte_start(byte_start), .byte_tx(byte_tx),
    .byte_done(byte_done), .byte_rx(byte_rx),
    .busy(busy), .frame_done(frame_done), .rx_count(rx_count)
  );

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge I_CLK) cyc <= cyc + 1;

  // scoreboard queues and reference model
  logic [DW-1:0] exp_byte_q[$];
  int            exp_frame_q[$];
  logic [DW-1:0] tx_model [DEPTH];
  logic [DW-1:0] rx_model [DEPTH];
  bit            rx_vld_model [DEPTH];
  int            rx_cnt_model = 0;
  int            frames_exp = 0;
  int            frames_seen = 0;

  // responder bookkeeping
  int            done_total = 0;
  int            last_done_cyc = 0;
  int            spur_req = 0;
  int            spur_ack = 0;
  bit            rand_delay = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SPI responder: echoes byte_tx+1 some cycles after each byte_start
  initial begin : responder
    bit            pending;
    int            wait_cnt;
    logic [DW-1:0] held;
    pending = 1'b0; wait_cnt = 0; held = '0;
    byte_done = 1'b0; byte_rx = '0;
    forever begin
      @(negedge I_CLK);
      byte_done = 1'b0;
      if (spur_ack != spur_req) begin
        spur_ack++;
        byte_done = 1'b1;
        byte_rx = DW'($urandom);
      end else if (pending) begin
        if (wait_cnt == 0) begin
          byte_done = 1'b1;
          byte_rx = DW'(held + 8'd1);
          last_done_cyc = cyc;
          done_total++;
          pending = 1'b0;
        end else begin
          wait_cnt--;
        end
      end else if (byte_start && !I_RESET) begin
        held = byte_tx;
        pending = 1'b1;
        wait_cnt = rand_delay ? int'($urandom_range(4, 0)) : 2;
      end
    end
  end

  // monitor: pops expectations whenever the DUT presents an output
  initial begin : monitor
    bit prev_bs;
    prev_bs = 1'b0;
    forever begin
      @(negedge I_CLK);
      if (byte_start) begin
        check("byte_start_one_cycle", 64'(prev_bs), 64'd0);
        check("byte_start_expected", 64'(exp_byte_q.size() > 0), 64'd1);
        if (exp_byte_q.size() > 0) check("byte_tx", 64'(byte_tx), 64'(exp_byte_q.pop_front()));
      end
      prev_bs = byte_start;
      if (frame_done) begin
        frames_seen++;
        check("frame_done_expected", 64'(exp_frame_q.size() > 0), 64'd1);
        if (exp_frame_q.size() > 0) void'(exp_frame_q.pop_front());
        check("frame_done_latency", 64'(cyc - last_done_cyc), 64'd1);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic write_tx(input int a, input logic [DW-1:0] d);
    @(negedge I_CLK);
    tx_wr_en = 1'b1; tx_waddr = AW'(a); tx_wdata = d;
    tx_model[a] = d;
    @(negedge I_CLK);
    tx_wr_en = 1'b0;
  endtask

  task automatic start_frame(input logic [AW:0] l, input bit chk_lat);
    int n;
    n = (int'(l) == 0 || int'(l) > DEPTH) ? DEPTH : int'(l);
    for (int i = 0; i < DEPTH; i++) rx_vld_model[i] = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_byte_q.push_back(tx_model[i]);
      rx_model[i] = DW'(tx_model[i] + 8'd1);
      rx_vld_model[i] = 1'b1;
    end
    rx_cnt_model = n;
    exp_frame_q.push_back(n);
    frames_exp++;
    @(negedge I_CLK);
    len = l; start = 1'b1;
`ifdef MSG_XFER_DEBOUNCE_EN
    repeat (40) @(negedge I_CLK);
    start = 1'b0;
    if (chk_lat) check("busy_after_press", 64'(busy | (exp_frame_q.size() == 0)), 64'd1);
`else
    @(negedge I_CLK);
    start = 1'b0;
    if (chk_lat) check("start_latency_t1", 64'(byte_start), 64'd0);
    @(negedge I_CLK);
    if (chk_lat) check("start_latency_t2", 64'(byte_start), 64'd1);
`endif
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (!busy && exp_frame_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge I_CLK);
    end
    check("frame_finished_in_budget", 64'(ok), 64'd1);
    check("tx_words_all_sent", 64'(exp_byte_q.size()), 64'd0);
  endtask

  task automatic read_rx(input int a, output logic [DW-1:0] d);
    @(negedge I_CLK);
    rd_addr = AW'(a);
    @(posedge I_CLK);
    #1 d = rd_data;
  endtask

  task automatic check_rx();
    logic [DW-1:0] d;
    check("rx_count", 64'(rx_count), 64'(rx_cnt_model));
    for (int i = 0; i < DEPTH; i++) begin
      read_rx(i, d);
      check($sformatf("rd_data[%0d]", i), 64'(d), 64'(rx_vld_model[i] ? rx_model[i] : 8'h00));
    end
  endtask

  initial begin : stimulus
    logic [47:0]   master;
    logic [47:0]   got;
    logic [DW-1:0] d;
    int            base;
    int            seen_before;
    master = "MASTER";
    start = 1'b0; len = '0; tx_wr_en = 1'b0; tx_waddr = '0; tx_wdata = '0; rd_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rx_model[i] = '0; rx_vld_model[i] = 1'b0; tx_model[i] = '0;
    end

    // reset state
    I_RESET = 1'b1;
    repeat (3) @(negedge I_CLK);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_frame_done", 64'(frame_done), 64'd0);
    check("reset_byte_start", 64'(byte_start), 64'd0);
    check("reset_byte_tx", 64'(byte_tx), 64'd0);
    check("reset_rx_count", 64'(rx_count), 64'd0);
    check("reset_rd_data", 64'(rd_data), 64'd0);
    I_RESET = 1'b0;

    // MASTER frame with a fixed 3-cycle echo
    for (int i = 6; i < DEPTH; i++) write_tx(i, DW'($urandom));
    for (int i = 0; i < 6; i++) write_tx(i, master[47-8*i -: 8]);
    rand_delay = 1'b0;
    start_frame(7'd6, 1'b1);
    wait_idle(2000);
    check_rx();
    for (int i = 0; i < 6; i++) begin
      read_rx(i, d);
      got[47-8*i -: 8] = d;
    end
    check("rx_string_NBTUFS", 64'(got), 64'h4E4254554653);

    // start while busy is ignored; spurious byte_done in IDLE is ignored
    rand_delay = 1'b1;
    for (int i = 0; i < 6; i++) write_tx(i, DW'($urandom));
    start_frame(7'd6, 1'b1);
    repeat (12) @(negedge I_CLK);
    start = 1'b1;
    @(negedge I_CLK);
    start = 1'b0;
    wait_idle(2000);
    spur_req++;
    repeat (10) @(negedge I_CLK);
    check("no_extra_frame", 64'(frames_seen), 64'(frames_exp));
    check_rx();

    // shorter frame clears stale RX entries
    start_frame(7'd2, 1'b1);
    wait_idle(2000);
    check_rx();

    // random short frames with TX writes landing beyond the active frame
    for (int f = 0; f < 3; f++) begin
      start_frame(7'($urandom_range(10, 1)), 1'b1);
      write_tx(int'($urandom_range(DEPTH-1, 20)), DW'($urandom));
      wait_idle(2000);
      check_rx();
    end

    // len=0 and len>DEPTH both mean a full DEPTH-word frame
    start_frame(7'd0, 1'b1);
    wait_idle(6000);
    check_rx();
    start_frame(7'd100, 1'b1);
    wait_idle(6000);
    check_rx();

    // reset after the third byte_done aborts without frame_done
    rand_delay = 1'b0;
    base = done_total;
    start_frame(7'd6, 1'b0);
    for (int k = 0; k < 500 && done_total < base + 3; k++) @(negedge I_CLK);
    @(negedge I_CLK);
    I_RESET = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_frame_done", 64'(frame_done), 64'd0);
    check("abort_byte_start", 64'(byte_start), 64'd0);
    exp_byte_q.delete();
    exp_frame_q.delete();
    frames_exp--;
    for (int i = 0; i < DEPTH; i++) rx_vld_model[i] = 1'b0;
    rx_cnt_model = 0;
    repeat (10) @(negedge I_CLK);
    I_RESET = 1'b0;
    repeat (10) @(negedge I_CLK);
    check_rx();

`ifdef MSG_XFER_DEBOUNCE_EN
    // a 10-cycle glitch is rejected, a 40-cycle hold gives one frame
    seen_before = frames_seen;
    @(negedge I_CLK);
    start = 1'b1;
    repeat (10) @(negedge I_CLK);
    start = 1'b0;
    repeat (60) @(negedge I_CLK);
    check("glitch_no_frame", 64'(frames_seen), 64'(seen_before));
    start_frame(7'd3, 1'b1);
    wait_idle(2000);
    check("hold_one_frame", 64'(frames_seen), 64'(seen_before + 1));
    check_rx();
`else
    seen_before = frames_seen;
`endif

    repeat (20) @(negedge I_CLK);
    check("frames_total", 64'(frames_seen), 64'(frames_exp));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/m_msg_xfer.md
M_MSG_XFER -- requirements
Module: m_msg_xfer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per SPI byte/word.
REQ-002 SHALL have parameter DEPTH, default 64, TX and RX buffer entries; power of two, 2..256; ADDR_W = clog2(DEPTH).
REQ-003 SHALL have parameter DEB_DIV, default 27000, debounce tick divider in I_CLK cycles; used only with MSG_XFER_DEBOUNCE_EN.
REQ-004 SHALL have port I_CLK  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port I_RESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  frame send request.
REQ-007 SHALL have port len  input  ADDR_W+1  frame length in words; 0 means DEPTH; values above DEPTH clamp to DEPTH.
REQ-008 SHALL have ports tx_wr_en / tx_waddr / tx_wdata  input  1 / ADDR_W / DATA_WIDTH  TX buffer write port.
REQ-009 SHALL have ports rd_addr  input  ADDR_W and rd_data  output  DATA_WIDTH  RX buffer read port for display.
REQ-010 SHALL have ports byte_start  output  1, byte_tx  output  DATA_WIDTH  word request to SPI control.
REQ-011 SHALL have ports byte_done  input  1, byte_rx  input  DATA_WIDTH  word completion from SPI control.
REQ-012 SHALL have outputs busy  1, frame_done  1, rx_count  ADDR_W+1.

Function
REQ-013 SHALL implement FSM IDLE -> LOAD -> SEND -> WAIT -> (LOAD | DONE) -> IDLE.
REQ-014 IDLE: accepted start latches the effective length, sets idx=0, clears all RX valid bits and rx_count, then enters LOAD.
REQ-015 LOAD: byte_tx <= tx_mem[idx]; next state SEND.
REQ-016 SEND: byte_start high for exactly one cycle; next state WAIT.
REQ-017 WAIT: on byte_done, rx_mem[idx] <= byte_rx, valid[idx] <= 1, rx_count += 1; if idx == len-1 go DONE, else idx += 1 and go LOAD.
REQ-018 DONE: frame_done high for exactly one cycle; next state IDLE.
REQ-019 Latency: start sampled at edge t gives byte_start high in cycle t+2; the last byte_done at edge u gives frame_done high in cycle u+1.
REQ-020 busy SHALL be high in every state except IDLE.
REQ-021 start while busy SHALL be ignored (not queued).
REQ-022 byte_done outside WAIT SHALL be ignored.
REQ-023 TX writes are always accepted, including mid-frame; a write to entry k takes effect for the frame only if it lands before the LOAD that reads k.
REQ-024 rd_data SHALL be registered (1-cycle latency) and SHALL return 0 for entries whose valid bit is clear.
REQ-025 A simultaneous RX write and read of the same entry SHALL return the old value.
REQ-026 rx_count SHALL saturate at DEPTH; idx SHALL never wrap within a frame.

Reset
REQ-027 I_RESET SHALL asynchronously force: state=IDLE, idx=0, rx_count=0, all valid bits=0, byte_start=0, byte_tx=0, frame_done=0, rd_data=0, debounce state cleared.
REQ-028 Reset mid-frame SHALL abort without frame_done; TX buffer contents are not required to be preserved.

Configuration
REQ-029 With macro MSG_XFER_DEBOUNCE_EN defined, start SHALL be treated as a raw button: sampled every DEB_DIV cycles into a shift register, and accepted once per press when 4 consecutive samples are high after a low sample.
REQ-030 Without MSG_XFER_DEBOUNCE_EN, start SHALL be a synchronous level, accepted on any cycle it is high in IDLE; DEB_DIV is unused.

Verification
REQ-031 Reset, load tx_mem[0..5]="MASTER", start with len=6, responder echoes byte_tx+1 after 3 cycles -> six byte_start pulses in order; frame_done once; rx_count=6; rd_data[0..5]="NBTUFS".
REQ-032 len=0, DEPTH=64 -> 64 words transferred; rx_count=64; idx does not wrap; frame_done once.
REQ-033 Second start during WAIT; spurious byte_done in IDLE -> no extra frame; RX unchanged.
REQ-034 New frame with len=2 after a 6-word frame -> rd_data[2..5]=0; rx_count=2.
REQ-035 I_RESET asserted after the 3rd byte_done -> immediate IDLE; busy=0; no frame_done; rd_data=0 for all entries.
REQ-036 MSG_XFER_DEBOUNCE_EN, DEB_DIV=4: 10-cycle glitch on start -> no frame; 40-cycle hold -> exactly one frame.
